// File: rtl/bypass_pkg.sv
// Shared encodings for the bypass request controller: FSM states,
// sequencer phase codes and the default debounce length.
package bypass_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 16;

  // Phase 1 is where the sequencer decides; phase 3 means it skipped ahead
  // (i.e. it honoured the bypass request).
  localparam logic [1:0] PH_DECIDE = 2'd1;
  localparam logic [1:0] PH_SKIP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CONSUME = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a counter debouncer. dout changes only
// after DEBOUNCE_CYCLES consecutive synchronised samples disagree with it.
module debounce_sync
  import bypass_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Bring the raw button into the clk domain before anything looks at it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Count consecutive mismatching samples; flip the level on the Nth one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (sync2 == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      dout <= ~dout;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/bypass_req_ctrl.sv
// Turns a bouncy push-button into a single registered bypass request for a
// 4-phase sequencer. One press gives at most one bypass; presses arriving
// while a request is still in flight are dropped and flagged with overrun.
// There is no handshake: bypass is a level held from the press until the
// sequencer either takes it (phase 1 -> 3) or abandons it (phase 1 -> 0/2).
module bypass_req_ctrl
  import bypass_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic [1:0] phase_in,
  output logic       bypass,
  output logic       taken,
  output logic       overrun,
  output logic       btn_level
);

  state_t state;
  logic   level_q;
  logic   press;

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .din  (btn_raw),
    .dout (btn_level)
  );

  // Only a rising debounced level is an event; releases are ignored.
  assign press = btn_level & ~level_q;

  // Previous-cycle copy of the debounced level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= btn_level;
  end

  // Request FSM with registered bypass/taken/overrun outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bypass  <= 1'b0;
      taken   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      taken   <= 1'b0;
      overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (press) begin
            state  <= ARMED;
            bypass <= 1'b1;
          end
        end
        ARMED: begin
          if (press) overrun <= 1'b1;
          if (phase_in == PH_DECIDE) state <= CONSUME;
        end
        CONSUME: begin
          if (press) overrun <= 1'b1;
          if (phase_in != PH_DECIDE) begin
            // Leaving phase 1 ends the request either way; only a skip to
            // phase 3 counts as the sequencer having used it.
            state  <= RELEASE;
            bypass <= 1'b0;
            taken  <= (phase_in == PH_SKIP);
          end
        end
        RELEASE: begin
          if (press) overrun <= 1'b1;
          if (!btn_level) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          bypass <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bypass_req_ctrl.sv
// Directed bench for bypass_req_ctrl with DEBOUNCE_CYCLES = 4. Each step
// drives the inputs, queues the expected {state, btn_level, bypass, taken,
// overrun} for the next edge, then pops and compares just after that edge.
module tb_bypass_req_ctrl;
  import bypass_pkg::*;

  localparam int W = 6;

  logic       clk;
  logic       reset;
  logic       btn_raw;
  logic [1:0] phase_in;
  logic       bypass;
  logic       taken;
  logic       overrun;
  logic       btn_level;

  logic [W-1:0] exp_q[$];
  int vectors;
  int miscompares;

  bypass_req_ctrl #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .phase_in (phase_in),
    .bypass   (bypass),
    .taken    (taken),
    .overrun  (overrun),
    .btn_level(btn_level)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input state_t s, input logic l,
                                      input logic b, input logic t,
                                      input logic o);
    return {s, l, b, t, o};
  endfunction

  // Scoreboard compare against the oldest queued expectation.
  task automatic check_now(input string tag);
    logic [W-1:0] exp;
    logic [W-1:0] obs;
    obs = {dut.state, btn_level, bypass, taken, overrun};
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed %b", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      vectors++;
      assert (obs === exp) else begin
        miscompares++;
        $error("FAIL %s: observed st/lvl/byp/tk/ov=%b expected %b", tag, obs, exp);
      end
    end
  endtask

  task automatic step(input logic b, input logic [1:0] ph,
                      input logic [W-1:0] exp, input string tag);
    btn_raw  = b;
    phase_in = ph;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check_now(tag);
  endtask

  task automatic step_n(input logic b, input logic [1:0] ph, input int n,
                        input logic [W-1:0] exp, input string tag);
    for (int i = 0; i < n; i++) step(b, ph, exp, tag);
  endtask

  // Debounced release from RELEASE back to IDLE takes 2+4 edges plus one.
  task automatic release_to_idle(input string tag);
    step_n(1'b0, 2'd0, 5, mk(RELEASE, 1, 0, 0, 0), tag);
    step(1'b0, 2'd0, mk(RELEASE, 0, 0, 0, 0), tag);
    step(1'b0, 2'd0, mk(IDLE, 0, 0, 0, 0), tag);
  endtask

  // Clean press from IDLE: level after 6 edges, bypass on the 7th.
  task automatic press_to_armed(input string tag);
    step_n(1'b1, 2'd0, 5, mk(IDLE, 0, 0, 0, 0), tag);
    step(1'b1, 2'd0, mk(IDLE, 1, 0, 0, 0), tag);
    step(1'b1, 2'd0, mk(ARMED, 1, 1, 0, 0), tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    btn_raw     = 1'b0;
    phase_in    = 2'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(mk(IDLE, 0, 0, 0, 0));
    check_now("reset_state");
    reset = 1'b0;

    // Clean press and taken sequence: phase 0,1,1,3
    press_to_armed("clean_press");
    step(1'b1, 2'd0, mk(ARMED, 1, 1, 0, 0), "armed_hold");
    step(1'b1, 2'd1, mk(CONSUME, 1, 1, 0, 0), "decide");
    step(1'b1, 2'd1, mk(CONSUME, 1, 1, 0, 0), "decide_hold");
    step(1'b1, 2'd3, mk(RELEASE, 1, 0, 1, 0), "taken");
    step(1'b1, 2'd0, mk(RELEASE, 1, 0, 0, 0), "taken_clear");
    release_to_idle("taken_release");

    // Abort: phase 1 then 0, no taken
    press_to_armed("abort_press");
    step(1'b1, 2'd1, mk(CONSUME, 1, 1, 0, 0), "abort_decide");
    step(1'b1, 2'd0, mk(RELEASE, 1, 0, 0, 0), "abort");
    step(1'b1, 2'd2, mk(RELEASE, 1, 0, 0, 0), "abort_hold");
    release_to_idle("abort_release");

    // Bounce: high 3, low 1, then high; glitch must restart the count
    step_n(1'b1, 2'd0, 3, mk(IDLE, 0, 0, 0, 0), "bounce_high");
    step(1'b0, 2'd0, mk(IDLE, 0, 0, 0, 0), "bounce_low");
    step_n(1'b1, 2'd0, 5, mk(IDLE, 0, 0, 0, 0), "bounce_wait");
    step(1'b1, 2'd0, mk(IDLE, 1, 0, 0, 0), "bounce_level");
    step(1'b1, 2'd0, mk(ARMED, 1, 1, 0, 0), "bounce_bypass");
    step_n(1'b1, 2'd0, 3, mk(ARMED, 1, 1, 0, 0), "bounce_single");

    // Overrun: release and re-press while ARMED; second press lands on a
    // phase-1 cycle so the transition and the overrun happen together.
    step_n(1'b0, 2'd0, 5, mk(ARMED, 1, 1, 0, 0), "ovr_release");
    step(1'b0, 2'd0, mk(ARMED, 0, 1, 0, 0), "ovr_released");
    step_n(1'b1, 2'd0, 5, mk(ARMED, 0, 1, 0, 0), "ovr_repress");
    step(1'b1, 2'd0, mk(ARMED, 1, 1, 0, 0), "ovr_level");
    step(1'b1, 2'd1, mk(CONSUME, 1, 1, 0, 1), "overrun");
    step(1'b1, 2'd1, mk(CONSUME, 1, 1, 0, 0), "overrun_clear");
    step(1'b1, 2'd3, mk(RELEASE, 1, 0, 1, 0), "ovr_taken");
    step(1'b1, 2'd3, mk(RELEASE, 1, 0, 0, 0), "taken_once");
    release_to_idle("ovr_idle");

    // Reset mid-request with button held
    press_to_armed("rst_press");
    step(1'b1, 2'd1, mk(CONSUME, 1, 1, 0, 0), "rst_consume");
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(mk(IDLE, 0, 0, 0, 0));
    check_now("async_reset_drop");
    @(posedge clk);
    #1;
    exp_q.push_back(mk(IDLE, 0, 0, 0, 0));
    check_now("reset_hold");
    reset = 1'b0;
    press_to_armed("rearm_after_reset");
    step(1'b1, 2'd0, mk(ARMED, 1, 1, 0, 0), "rearm_hold");

    if (exp_q.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
